// File: rtl/spi_resp_regfile_pkg.sv
// Shared types and constants for the MAX3421E-style SPI register responder.
package spi_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } spi_state_t;

    localparam int           ADDR_W       = 5;
    localparam logic [4:0]   REG_HIRQ     = 5'd25;
    localparam logic [4:0]   REG_HIEN     = 5'd26;
    localparam int           CMD_DIR_BIT  = 1;
    localparam int           CMD_ADDR_MSB = 7;
    localparam int           CMD_ADDR_LSB = 3;

endpackage

// File: rtl/spi_resp_regfile_if.sv
// SPI link, local fabric port and write-observation signals of the responder.
interface spi_resp_regfile_if;

    logic       spi_ss_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       irq_n;
    logic [4:0] loc_addr;
    logic       loc_we;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    modport slave (
        input  spi_ss_n, spi_sclk, spi_mosi, loc_addr, loc_we, loc_wdata,
        output spi_miso, spi_miso_oe, irq_n, loc_rdata, wr_strobe, wr_addr, wr_data, busy
    );

    modport master (
        output spi_ss_n, spi_sclk, spi_mosi, loc_addr, loc_we, loc_wdata,
        input  spi_miso, spi_miso_oe, irq_n, loc_rdata, wr_strobe, wr_addr, wr_data, busy
    );

endinterface

// File: rtl/spi_resp_regfile_edge_sync.sv
// Two-flop synchronizer with single-cycle rise/fall pulses in the clk domain.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [2:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {3{RST_VAL}};
        end else begin
            q <= {q[1:0], din};
        end
    end

    assign sync = q[1];
    assign rise = q[1] & ~q[2];
    assign fall = ~q[1] & q[2];

endmodule

// File: rtl/spi_resp_regfile.sv
// SPI mode-0 responder emulating MAX3421E register access over a 32x8 register file.
// Define SPI_RESP_IRQ_EN for HIRQ write-1-to-clear semantics and a live irq_n output.
module spi_resp_regfile
    import spi_resp_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int SCLK_DIV = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_resp_regfile_if.slave bus
);

    localparam int MIN_HALF = SCLK_DIV / 2;

    logic       ss_sync, ss_rise, ss_fall;
    logic       sclk_sync, sclk_rise, sclk_fall;
    logic [1:0] mosi_q;
    logic       mosi_sync;

    // ss_n sync resets low so a reset released mid-transaction never fakes a select edge.
    spi_edge_sync #(.RST_VAL(1'b0)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.spi_ss_n),
        .sync (ss_sync),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.spi_sclk),
        .sync (sclk_sync),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_q <= 2'b00;
        end else begin
            mosi_q <= {mosi_q[0], bus.spi_mosi};
        end
    end

    assign mosi_sync = mosi_q[1];

    spi_state_t        state, state_next;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_in, shift_out, byte_in;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_dir;
    logic              active, byte_done, spi_we;
    logic [7:0]        regs [NREGS];
    logic [7:0]        loc_rdata_q, wr_data_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_strobe_q, irq_n_q;

    assign active  = (state != IDLE) && !ss_sync && !ss_fall;
    assign byte_in = {shift_in[6:0], mosi_sync};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_done  = 1'b0;
        spi_we     = 1'b0;
        if (ss_fall) begin
            state_next = CMD;
        end else if (ss_rise) begin
            state_next = IDLE;
        end else if (active && sclk_rise && bit_cnt == 3'd7) begin
            byte_done = 1'b1;
            if (state == CMD) begin
                state_next = DATA;
            end else begin
                spi_we = cmd_dir;
            end
        end
    end

    // A fall with bit_cnt at zero is the first fall after a byte boundary: load instead of shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            shift_in  <= 8'h00;
            shift_out <= 8'h00;
            cmd_addr  <= '0;
            cmd_dir   <= 1'b0;
        end else if (ss_fall) begin
            bit_cnt   <= 3'd0;
            shift_out <= regs[REG_HIRQ];
        end else if (ss_rise) begin
            bit_cnt <= 3'd0;
        end else if (active) begin
            if (sclk_rise) begin
                shift_in <= byte_in;
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (byte_done && state == CMD) begin
                cmd_addr <= byte_in[CMD_ADDR_MSB:CMD_ADDR_LSB];
                cmd_dir  <= byte_in[CMD_DIR_BIT];
            end
            if (sclk_fall) begin
                shift_out <= (bit_cnt == 3'd0) ? regs[cmd_addr] : {shift_out[6:0], 1'b0};
            end
        end
    end

`ifdef SPI_RESP_IRQ_EN
    logic [7:0] hirq_set, hirq_clr;

    always_comb begin
        hirq_set = 8'h00;
        hirq_clr = 8'h00;
        if (bus.loc_we && bus.loc_addr == REG_HIRQ) hirq_set = bus.loc_wdata;
        if (spi_we && cmd_addr == REG_HIRQ)         hirq_clr = byte_in;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
        end else begin
`ifdef SPI_RESP_IRQ_EN
            if (bus.loc_we && bus.loc_addr != REG_HIRQ && !(spi_we && cmd_addr == bus.loc_addr))
                regs[bus.loc_addr] <= bus.loc_wdata;
            if (spi_we && cmd_addr != REG_HIRQ)
                regs[cmd_addr] <= byte_in;
            regs[REG_HIRQ] <= (regs[REG_HIRQ] & ~hirq_clr) | hirq_set;
`else
            if (bus.loc_we && !(spi_we && cmd_addr == bus.loc_addr))
                regs[bus.loc_addr] <= bus.loc_wdata;
            if (spi_we)
                regs[cmd_addr] <= byte_in;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loc_rdata_q <= 8'h00;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            irq_n_q     <= 1'b1;
        end else begin
            loc_rdata_q <= regs[bus.loc_addr];
            wr_strobe_q <= spi_we;
            if (spi_we) begin
                wr_addr_q <= cmd_addr;
                wr_data_q <= byte_in;
            end
`ifdef SPI_RESP_IRQ_EN
            irq_n_q <= ~|(regs[REG_HIRQ] & regs[REG_HIEN]);
`else
            irq_n_q <= 1'b1;
`endif
        end
    end

    assign bus.spi_miso    = shift_out[7];
    assign bus.spi_miso_oe = (state != IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.loc_rdata   = loc_rdata_q;
    assign bus.wr_strobe   = wr_strobe_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.irq_n       = irq_n_q;

    // Link sanity: SCLK phases long enough for the synchronizer, and SCLK idle low at select.
    logic [3:0] phase_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt <= 4'd0;
        end else if (sclk_rise || sclk_fall) begin
            phase_cnt <= 4'd0;
        end else if (phase_cnt != 4'hF) begin
            phase_cnt <= phase_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (active && (sclk_rise || sclk_fall)) assert (int'(phase_cnt) >= MIN_HALF - 1);
            if (ss_fall) assert (!sclk_sync);
        end
    end

endmodule
